// File: rtl/pfd_walk_filter.sv
// Three-state phase/frequency detector with random-walk vote filter for an ADPLL.
// Emits one-cycle UP/DN corrections plus the last phase error and a lock flag.
module pfd_walk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_N      = 8,
  parameter int TIMEOUT     = 255,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ref_in,
  input  logic       fb_in,
  output logic       UP,
  output logic       DN,
  output logic [7:0] err_width,
  output logic       lead,
  output logic       lag,
  output logic       lock
);

  typedef enum logic [1:0] {IDLE, LEAD, LAG} state_t;

  localparam logic [7:0]        TIMEOUT_W  = 8'(TIMEOUT);
  localparam logic [7:0]        LOCK_TOL_W = 8'(LOCK_TOL);
  localparam logic [7:0]        LOCK_CNT_W = 8'(LOCK_CNT);
  localparam logic signed [4:0] WALK_LIM   = 5'(FILT_N - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_ref_q, sync_ref_d, sync_fb_q, sync_fb_d;
  logic                   dly_ref_q, dly_fb_q;
  logic                   rise_ref, rise_fb;

  state_t            state_q, state_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic signed [4:0] walk_q, walk_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [7:0]        err_width_q, err_width_d;
  logic              lead_q, lead_d, lag_q, lag_d;
  logic              up_q, up_d, dn_q, dn_d, lock_q, lock_d;

  logic              done, tmo;
  logic [7:0]        width;
  logic signed [1:0] vote;

  // Stage 0: input synchronizers and edge detect (free-running)
  always_comb begin
    sync_ref_d = {sync_ref_q[SYNC_STAGES-2:0], ref_in};
    sync_fb_d  = {sync_fb_q[SYNC_STAGES-2:0], fb_in};
  end

  assign rise_ref = sync_ref_q[SYNC_STAGES-1] & ~dly_ref_q;
  assign rise_fb  = sync_fb_q[SYNC_STAGES-1] & ~dly_fb_q;

  // Stage 1: phase detector, walk filter and lock tracking
  always_comb begin
    state_d     = state_q;
    err_cnt_d   = err_cnt_q;
    walk_d      = walk_q;
    lock_cnt_d  = lock_cnt_q;
    err_width_d = err_width_q;
    lead_d      = lead_q;
    lag_d       = lag_q;
    lock_d      = lock_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
    width       = 8'd0;
    vote        = 2'sd0;

    if (!enable) begin
      state_d    = IDLE;
      err_cnt_d  = 8'd0;
      walk_d     = 5'sd0;
      lock_cnt_d = 8'd0;
      lock_d     = 1'b0;
      lead_d     = 1'b0;
      lag_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_ref && rise_fb) begin
            done   = 1'b1;
            lead_d = 1'b0;
            lag_d  = 1'b0;
          end else if (rise_ref) begin
            state_d   = LEAD;
            err_cnt_d = 8'd1;
          end else if (rise_fb) begin
            state_d   = LAG;
            err_cnt_d = 8'd1;
          end
        end
        LEAD: begin
          if (rise_fb) begin
            done   = 1'b1;
            width  = err_cnt_q;
            vote   = 2'sd1;
            lead_d = 1'b1;
            lag_d  = 1'b0;
            // A ref edge coinciding with the closing edge opens the next comparison
            state_d   = rise_ref ? LEAD : IDLE;
            err_cnt_d = rise_ref ? 8'd1 : 8'd0;
          end else if (err_cnt_q == TIMEOUT_W) begin
            done      = 1'b1;
            tmo       = 1'b1;
            width     = TIMEOUT_W;
            vote      = 2'sd1;
            lead_d    = 1'b1;
            lag_d     = 1'b0;
            state_d   = IDLE;
            err_cnt_d = 8'd0;
          end else begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        LAG: begin
          if (rise_ref) begin
            done      = 1'b1;
            width     = err_cnt_q;
            vote      = -2'sd1;
            lead_d    = 1'b0;
            lag_d     = 1'b1;
            state_d   = rise_fb ? LAG : IDLE;
            err_cnt_d = rise_fb ? 8'd1 : 8'd0;
          end else if (err_cnt_q == TIMEOUT_W) begin
            done      = 1'b1;
            tmo       = 1'b1;
            width     = TIMEOUT_W;
            vote      = -2'sd1;
            lead_d    = 1'b0;
            lag_d     = 1'b1;
            state_d   = IDLE;
            err_cnt_d = 8'd0;
          end else begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (done) begin
        err_width_d = width;
        if (vote > 2'sd0) begin
          if (walk_q == WALK_LIM) begin
            walk_d = 5'sd0;
            up_d   = 1'b1;
          end else begin
            walk_d = walk_q + 5'sd1;
          end
        end else if (vote < 2'sd0) begin
          if (walk_q == -WALK_LIM) begin
            walk_d = 5'sd0;
            dn_d   = 1'b1;
          end else begin
            walk_d = walk_q - 5'sd1;
          end
        end
        if (!tmo && (width <= LOCK_TOL_W)) begin
          lock_cnt_d = sat_inc8(lock_cnt_q);
          lock_d     = (lock_cnt_d >= LOCK_CNT_W);
        end else begin
          lock_cnt_d = 8'd0;
          lock_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ref_q  <= '0;
      sync_fb_q   <= '0;
      dly_ref_q   <= 1'b0;
      dly_fb_q    <= 1'b0;
      state_q     <= IDLE;
      err_cnt_q   <= 8'd0;
      walk_q      <= 5'sd0;
      lock_cnt_q  <= 8'd0;
      err_width_q <= 8'd0;
      lead_q      <= 1'b0;
      lag_q       <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      sync_ref_q  <= sync_ref_d;
      sync_fb_q   <= sync_fb_d;
      dly_ref_q   <= sync_ref_q[SYNC_STAGES-1];
      dly_fb_q    <= sync_fb_q[SYNC_STAGES-1];
      state_q     <= state_d;
      err_cnt_q   <= err_cnt_d;
      walk_q      <= walk_d;
      lock_cnt_q  <= lock_cnt_d;
      err_width_q <= err_width_d;
      lead_q      <= lead_d;
      lag_q       <= lag_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      lock_q      <= lock_d;
    end
  end

  assign UP        = up_q;
  assign DN        = dn_q;
  assign err_width = err_width_q;
  assign lead      = lead_q;
  assign lag       = lag_q;
  assign lock      = lock_q;

endmodule
